// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract accumulator: opcodes, FSM states, default width.
package addsub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_HOLD = 2'b10
  } state_e;

endpackage

// File: rtl/addsub_core.sv
// Combinational ripple-carry add/subtract: mode=1 inverts b and injects carry-in 1.
module addsub_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH-1:0] b_eff;
  logic             c;

  // The chain is walked in one process so the carry variable ripples bit by bit.
  always_comb begin
    b_eff = b ^ {WIDTH{mode}};
    c     = mode;
    sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b_eff[i] ^ c;
      c      = (a[i] & b_eff[i]) | (c & (a[i] ^ b_eff[i]));
    end
    carry = c;
  end

endmodule

// File: rtl/addsub_acc.sv
// Accumulator stage: accepts one command per handshake, executes it on the add/sub core,
// and holds the registered result and flags until the consumer takes them.
module addsub_acc
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_operand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             neg
);

  localparam int MSB = WIDTH - 1;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;

  logic             core_mode;
  logic [WIDTH-1:0] core_sum;
  logic             core_carry;
  logic             core_ovf;

  assign core_mode = (op_q == OP_SUB);

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a     (acc_q),
    .b     (operand_q),
    .mode  (core_mode),
    .sum   (core_sum),
    .carry (core_carry)
  );

  // B' msb is the operand msb after the optional inversion inside the core.
  assign core_ovf = (acc_q[MSB] == (operand_q[MSB] ^ core_mode)) &&
                    (core_sum[MSB] != acc_q[MSB]);

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d    = state_q;
    op_d       = op_q;
    operand_d  = operand_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    neg_d      = neg_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d      = op_e'(in_op);
          operand_d = in_operand;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (op_q)
          OP_LOAD: begin acc_d = operand_q; carry_d = 1'b0;       overflow_d = 1'b0;     end
          OP_CLR:  begin acc_d = '0;        carry_d = 1'b0;       overflow_d = 1'b0;     end
          default: begin acc_d = core_sum;  carry_d = core_carry; overflow_d = core_ovf; end
        endcase
        zero_d  = (acc_d == '0);
        neg_d   = acc_d[MSB];
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample the pre-edge values together.
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= OP_LOAD;
      operand_q  <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b1;
      neg_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      operand_q  <= operand_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_HOLD);
  assign acc       = acc_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign neg       = neg_q;

endmodule

// File: tb/tb_addsub_acc.sv
// Self-checking bench for addsub_acc: directed table, hold/reset corner cases, random vs model.
module tb_addsub_acc;

  localparam int W = 4;
  localparam logic [1:0] C_LOAD = 2'b00;
  localparam logic [1:0] C_ADD  = 2'b01;
  localparam logic [1:0] C_SUB  = 2'b10;
  localparam logic [1:0] C_CLR  = 2'b11;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] opnd;
    logic [W-1:0] acc;
    logic         c;
    logic         v;
    logic         z;
    logic         n;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   in_op = '0;
  logic [W-1:0] in_operand = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] acc;
  logic         carry, overflow, zero, neg;

  int n_vec = 0;
  int n_miscomp = 0;
  int model_acc = 0;

  addsub_acc #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_operand (in_operand),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .acc        (acc),
    .carry      (carry),
    .overflow   (overflow),
    .zero       (zero),
    .neg        (neg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscomp++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_res(input string tag, input vec_t e);
    check({tag, ".acc"},      32'(acc),      32'(e.acc));
    check({tag, ".carry"},    32'(carry),    32'(e.c));
    check({tag, ".overflow"}, 32'(overflow), 32'(e.v));
    check({tag, ".zero"},     32'(zero),     32'(e.z));
    check({tag, ".neg"},      32'(neg),      32'(e.n));
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic vec_t model(input logic [1:0] op, input int a, input int b);
    vec_t e;
    int sa, sb, r, s;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    e.op = op;
    e.opnd = b[W-1:0];
    e.c = 1'b0;
    e.v = 1'b0;
    case (op)
      C_LOAD: r = b;
      C_CLR:  r = 0;
      C_ADD: begin
        r = a + b;
        e.c = (r > 15);
        s = sa + sb;
        e.v = (s > 7) || (s < -8);
      end
      default: begin
        r = a - b;
        e.c = (a >= b);
        s = sa - sb;
        e.v = (s > 7) || (s < -8);
      end
    endcase
    r = r & 15;
    e.acc = r[W-1:0];
    e.z = (r == 0);
    e.n = (r >= 8);
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the result edge.
  task automatic send(input logic [1:0] op, input logic [W-1:0] opnd);
    int n = 0;
    in_valid = 1'b1;
    in_op = op;
    in_operand = opnd;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("exec.out_valid", 32'(out_valid), 32'd0);
    check("exec.in_ready",  32'(in_ready),  32'd0);
    @(negedge clk);
    check("result.out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release.in_ready",  32'(in_ready),  32'd1);
    check("release.out_valid", 32'(out_valid), 32'd0);
  endtask

  vec_t tbl[12];
  vec_t e;

  initial begin
    tbl[0]  = '{C_LOAD, 4'd5,  4'd5,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{C_ADD,  4'd3,  4'd8,  1'b0, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{C_LOAD, 4'd5,  4'd5,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{C_SUB,  4'd3,  4'd2,  1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{C_LOAD, 4'd3,  4'd3,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{C_SUB,  4'd5,  4'd14, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{C_LOAD, 4'd8,  4'd8,  1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{C_SUB,  4'd2,  4'd6,  1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{C_LOAD, 4'd15, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{C_ADD,  4'd1,  4'd0,  1'b1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{C_CLR,  4'd0,  4'd0,  1'b0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{C_CLR,  4'd7,  4'd0,  1'b0, 1'b0, 1'b1, 1'b0};

    // Reset state, including in_ready low while rst is high.
    @(negedge clk);
    @(negedge clk);
    check("rst.in_ready",  32'(in_ready),  32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check_res("rst", '{C_CLR, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0});
    rst = 1'b0;
    @(negedge clk);
    check("post_rst.in_ready", 32'(in_ready), 32'd1);

    foreach (tbl[i]) begin
      send(tbl[i].op, tbl[i].opnd);
      check_res($sformatf("tbl%0d", i), tbl[i]);
      release_out();
    end

    // Consumer stalls 4 cycles in HOLD while upstream offers a command.
    send(C_LOAD, 4'd6);
    in_valid = 1'b1;
    in_op = C_ADD;
    in_operand = 4'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold.out_valid", 32'(out_valid), 32'd1);
      check("hold.in_ready",  32'(in_ready),  32'd0);
      check_res("hold", '{C_LOAD, 4'd6, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0});
    end
    in_valid = 1'b0;
    release_out();
    @(negedge clk);
    check_res("hold_unconsumed", '{C_LOAD, 4'd6, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0});
    send(C_ADD, 4'd1);
    check_res("after_hold", '{C_ADD, 4'd1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0});
    release_out();

    // Reset pulsed while the command is in EXEC.
    in_valid = 1'b1;
    in_op = C_ADD;
    in_operand = 4'd3;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    check("abort.in_ready_rst", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("abort.out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    check_res("abort", '{C_CLR, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0});
    check("abort.in_ready", 32'(in_ready), 32'd1);
    model_acc = 0;

    // Random commands with random consumer back-pressure.
    for (int i = 0; i < 200; i++) begin
      logic [1:0]   op;
      logic [W-1:0] b;
      int           stall;
      op = 2'($urandom_range(0, 3));
      b  = W'($urandom_range(0, 15));
      e  = model(op, model_acc, int'(b));
      send(op, b);
      stall = $urandom_range(0, 2);
      for (int s = 0; s < stall; s++) @(negedge clk);
      check_res($sformatf("rnd%0d", i), e);
      model_acc = int'(e.acc);
      release_out();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
    $finish;
  end

endmodule
